id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage that directly feeds the ALU.
//  - Registers decoded fields once per cycle.
//  - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
//  - Detects load-use hazards: stalls ID and inserts a bubble.
//  - Squashes the held instruction on a taken-branch flush.
//  - Drives alusrc1/alusrc2/aluop straight into the ALU.
// PARAMETERS
//  XLEN      32  datapath width; equals `instWidth
//  ALUOP_W   5   ALU opcode width; equals `aluOP
//  REG_AW    5   register-file address width
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous, active-high reset
//  id_valid       in   1        ID holds a real instruction
//  id_pc          in   XLEN     PC of ID instruction
//  id_rs1_addr    in   REG_AW   source register 1 index
//  id_rs2_addr    in   REG_AW   source register 2 index
//  id_rs1_data    in   XLEN     register-file read data, rs1
//  id_rs2_data    in   XLEN     register-file read data, rs2
//  id_imm         in   XLEN     sign-extended immediate
//  id_aluop       in   ALUOP_W  ALU operation code
//  id_src1_pc     in   1        1: alusrc1 = PC, 0: rs1
//  id_src2_imm    in   1        1: alusrc2 = imm, 0: rs2
//  id_rd_addr     in   REG_AW   destination register
//  id_reg_write   in   1        instruction writes rd
//  id_mem_read    in   1        instruction is a load
//  id_mem_write   in   1        instruction is a store
//  ex_hold        in   1        downstream freeze; hold all EX state
//  flush          in   1        taken branch; squash the EX register contents
//  exmem_rd       in   REG_AW   EX/MEM destination register
//  exmem_we       in   1        EX/MEM writes rd
//  exmem_result   in   XLEN     EX/MEM ALU result
//  memwb_rd       in   REG_AW   MEM/WB destination register
//  memwb_we       in   1        MEM/WB writes rd
//  memwb_result   in   XLEN     MEM/WB writeback data
//  alusrc1        out  XLEN     ALU operand 1, combinational after forwarding
//  alusrc2        out  XLEN     ALU operand 2, combinational after forwarding
//  aluop          out  ALUOP_W  registered ALU opcode
//  ex_valid       out  1        EX stage holds a real instruction
//  ex_pc          out  XLEN     registered PC
//  ex_imm         out  XLEN     registered immediate (branch target calculation)
//  ex_store_data  out  XLEN     forwarded rs2 value, used as store data
//  ex_rd_addr     out  REG_AW   registered rd
//  ex_reg_write   out  1        registered write enable, gated by ex_valid
//  ex_mem_read    out  1        registered load flag, gated by ex_valid
//  ex_mem_write   out  1        registered store flag, gated by ex_valid
//  id_stall       out  1        combinational; freeze PC and IF/ID
// BEHAVIOUR
//  - Latency: ID fields appear at the EX outputs 1 cycle after capture.
//  - Reset: all registers clear to zero, so ex_valid, ex_reg_write, ex_mem_read,
//    ex_mem_write = 0 and aluop = ALU_NOP (`aluPlus).
//    Operands read 0 while no forwarding is active.
//  - Bubble: valid, reg_write, mem_read, mem_write = 0; aluop = ALU_NOP; rd = 0.
//  - Load-use hazard:
//    id_stall = id_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 &
//               (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
//    Also id_stall = 1 whenever ex_hold = 1.
//  - Register update priority, per clock edge:
//    rst > flush > ex_hold > load-use > normal.
//    - rst or flush: load a bubble.
//    - ex_hold: keep all EX state unchanged.
//    - load-use: load a bubble.
//    - normal: capture ID (a bubble if id_valid = 0).
//  - flush and ex_hold together: flush wins. The stage becomes a bubble and
//    id_stall still follows ex_hold.
//  - Forwarding, per source register r (rs1 or rs2):
//    - If exmem_we & exmem_rd==r & r!=0: use exmem_result.
//    - Else if memwb_we & memwb_rd==r & r!=0: use memwb_result.
//    - Else: use the registered register-file data.
//    - EX/MEM has priority over MEM/WB. x0 is never forwarded and always reads 0.
//  - alusrc1 = src1_pc ? ex_pc : fwd_rs1.
//  - alusrc2 = src2_imm ? ex_imm : fwd_rs2.
//  - ex_store_data = fwd_rs2, always.
//  - Forwarding is evaluated every cycle, including during ex_hold, so
//    producers that retire during a hold are picked up.
//  - No arithmetic in this block; all widths pass through unchanged.
// STRUCTURE
//  - `instWidth, `aluOP and ALU_NOP (= `aluPlus) come from define.v.
//  - Add a new define there: ZERO_REG = 0.
//  - Sub-module operand_fwd_mux, combinational, instantiated twice (rs1, rs2).
//    Inputs: reg addr, reg data, exmem_{rd,we,result}, memwb_{rd,we,result}.
//    Output: forwarded value.
//  - Hazard logic and the pipeline register live in the top module.
// TESTING
//  1. Reset:
//     rst=1 for 2 cycles -> ex_valid=0, aluop=ALU_NOP, id_stall=0, alusrc1=alusrc2=0.
//  2. Pass-through:
//     id add, rs1 data=5, rs2 data=7, no hazards -> next cycle alusrc1=5, alusrc2=7, ex_valid=1.
//  3. Forward priority:
//     exmem_rd=memwb_rd=3 (both we=1), exmem_result=0xAA, memwb_result=0xBB,
//     EX rs1=3 -> alusrc1=0xAA. Repeat with rs1=0 -> alusrc1=0.
//  4. Load-use:
//     EX holds lw x4, ID holds add using rs2=x4 -> id_stall=1 for exactly 1 cycle,
//     then a bubble (ex_valid=0). Next cycle the add enters; with memwb_rd=4,
//     memwb_result=0x55 it gives alusrc2=0x55.
//  5. Flush and hold:
//     flush=1 and ex_hold=1 in the same cycle -> next ex_valid=0 and ex_reg_write=0.
//     ex_hold alone for 3 cycles -> EX outputs frozen, id_stall=1 throughout.
//  6. Reset mid-stall:
//     rst during a load-use stall -> bubble next cycle and id_stall=0 after rst deasserts.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage_pkg
//   Shared constants and types for the ID/EX operand stage.
//   - Default datapath, ALU-opcode and register-address widths.
//   - ALU opcode encodings used by this stage (ALU_NOP aliases ALU_PLUS, so a
//     register cleared to zero already decodes as a NOP).
//   - ZERO_REG: index of the hard-wired zero register.
//   - ex_action_e: what the EX register does on the coming clock edge.
// ---------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int ALUOP_W_DEF = 5;
  localparam int REG_AW_DEF  = 5;

  localparam logic [ALUOP_W_DEF-1:0] ALU_PLUS = 5'd0;
  localparam logic [ALUOP_W_DEF-1:0] ALU_NOP  = ALU_PLUS;

  localparam logic [REG_AW_DEF-1:0] ZERO_REG = 5'd0;

  // Per-edge update decision for the EX register.
  typedef enum logic [1:0] {
    ACT_CAPTURE = 2'd0,  // load the ID fields
    ACT_BUBBLE  = 2'd1,  // load an all-zero bubble
    ACT_HOLD    = 2'd2   // keep the current contents
  } ex_action_e;

endpackage : id_ex_operand_stage_pkg

// File: rtl/id_ex_operand_stage_fwd.sv
// ---------------------------------------------------------------------------
// operand_fwd_mux
//   Combinational forwarding mux for one source register.
//   Priority: EX/MEM result, then MEM/WB result, then register-file data.
//   The zero register is never forwarded and always reads as zero.
// Ports
//   reg_addr_i      source register index
//   reg_data_i      register-file data captured with the instruction
//   exmem_rd_i/we_i/result_i   EX/MEM producer
//   memwb_rd_i/we_i/result_i   MEM/WB producer
//   fwd_data_o      resolved operand value
// ---------------------------------------------------------------------------
module operand_fwd_mux
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] reg_addr_i,
  input  logic [XLEN-1:0]   reg_data_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_we_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_we_i,
  input  logic [XLEN-1:0]   memwb_result_i,
  output logic [XLEN-1:0]   fwd_data_o
);

  logic is_zero_reg;
  logic hit_exmem;
  logic hit_memwb;

  always_comb begin
    is_zero_reg = (reg_addr_i == REG_AW'(ZERO_REG));
    hit_exmem   = exmem_we_i && (exmem_rd_i == reg_addr_i) && !is_zero_reg;
    hit_memwb   = memwb_we_i && (memwb_rd_i == reg_addr_i) && !is_zero_reg;

    fwd_data_o = reg_data_i;
    if (is_zero_reg) begin
      fwd_data_o = '0;
    end else if (hit_exmem) begin
      // The younger producer carries the newest value.
      fwd_data_o = exmem_result_i;
    end else if (hit_memwb) begin
      fwd_data_o = memwb_result_i;
    end
  end

endmodule : operand_fwd_mux

// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus operand selection feeding the ALU.
//   - Captures decoded ID fields once per cycle (1-cycle latency to EX).
//   - Forwards from EX/MEM and MEM/WB (two operand_fwd_mux instances).
//   - Detects load-use hazards: stalls ID and inserts a bubble.
//   - Squashes the EX contents on flush; freezes them on ex_hold.
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   id_*                        decoded instruction from ID
//   ex_hold, flush              downstream freeze / taken-branch squash
//   exmem_*, memwb_*            forwarding producers
//   alusrc1, alusrc2, aluop     ALU operands (combinational) and opcode
//   ex_*                        registered EX-stage fields
//   id_stall                    freeze PC and IF/ID this cycle
// Flow control
//   id_valid/ex_valid are qualifiers, not handshakes: a field is meaningful
//   only while its valid is high. id_stall is the only back-pressure; when
//   it is high the ID instruction is not consumed this edge and ID must
//   present it again next cycle.
// ---------------------------------------------------------------------------
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int REG_AW  = REG_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [REG_AW-1:0]  id_rs1_addr,
  input  logic [REG_AW-1:0]  id_rs2_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic               id_src1_pc,
  input  logic               id_src2_imm,
  input  logic [REG_AW-1:0]  id_rd_addr,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               ex_hold,
  input  logic               flush,
  input  logic [REG_AW-1:0]  exmem_rd,
  input  logic               exmem_we,
  input  logic [XLEN-1:0]    exmem_result,
  input  logic [REG_AW-1:0]  memwb_rd,
  input  logic               memwb_we,
  input  logic [XLEN-1:0]    memwb_result,
  output logic [XLEN-1:0]    alusrc1,
  output logic [XLEN-1:0]    alusrc2,
  output logic [ALUOP_W-1:0] aluop,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_imm,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [REG_AW-1:0]  ex_rd_addr,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               id_stall
);

  // EX register
  logic               valid_q,     valid_d;
  logic [XLEN-1:0]    pc_q,        pc_d;
  logic [REG_AW-1:0]  rs1_addr_q,  rs1_addr_d;
  logic [REG_AW-1:0]  rs2_addr_q,  rs2_addr_d;
  logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0]    imm_q,       imm_d;
  logic [ALUOP_W-1:0] aluop_q,     aluop_d;
  logic               src1_pc_q,   src1_pc_d;
  logic               src2_imm_q,  src2_imm_d;
  logic [REG_AW-1:0]  rd_q,        rd_d;
  logic               reg_write_q, reg_write_d;
  logic               mem_read_q,  mem_read_d;
  logic               mem_write_q, mem_write_d;

  logic       load_use;
  ex_action_e ex_action;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // ------------------------------------------------------------------
  // Hazard detection and update decision
  // ------------------------------------------------------------------
  always_comb begin
    load_use = id_valid && valid_q && mem_read_q &&
               (rd_q != REG_AW'(ZERO_REG)) &&
               ((rd_q == id_rs1_addr) || (rd_q == id_rs2_addr));

    // ex_hold freezes ID too, independent of any flush in the same cycle.
    id_stall = ex_hold || load_use;

    if (flush) begin
      ex_action = ACT_BUBBLE;
    end else if (ex_hold) begin
      ex_action = ACT_HOLD;
    end else if (load_use) begin
      ex_action = ACT_BUBBLE;
    end else if (id_valid) begin
      ex_action = ACT_CAPTURE;
    end else begin
      ex_action = ACT_BUBBLE;
    end
  end

  // ------------------------------------------------------------------
  // Next-state for the EX register
  // ------------------------------------------------------------------
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    aluop_d     = aluop_q;
    src1_pc_d   = src1_pc_q;
    src2_imm_d  = src2_imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;

    case (ex_action)
      ACT_CAPTURE: begin
        valid_d     = 1'b1;
        pc_d        = id_pc;
        rs1_addr_d  = id_rs1_addr;
        rs2_addr_d  = id_rs2_addr;
        rs1_data_d  = id_rs1_data;
        rs2_data_d  = id_rs2_data;
        imm_d       = id_imm;
        aluop_d     = id_aluop;
        src1_pc_d   = id_src1_pc;
        src2_imm_d  = id_src2_imm;
        rd_d        = id_rd_addr;
        reg_write_d = id_reg_write;
        mem_read_d  = id_mem_read;
        mem_write_d = id_mem_write;
      end
      ACT_BUBBLE: begin
        // Bubble equals the reset image: source regs become x0, so the
        // operands read zero and nothing can be forwarded into them.
        valid_d     = 1'b0;
        pc_d        = '0;
        rs1_addr_d  = REG_AW'(ZERO_REG);
        rs2_addr_d  = REG_AW'(ZERO_REG);
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        aluop_d     = ALUOP_W'(ALU_NOP);
        src1_pc_d   = 1'b0;
        src2_imm_d  = 1'b0;
        rd_d        = REG_AW'(ZERO_REG);
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      default: ;  // ACT_HOLD keeps everything
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      aluop_q     <= ALUOP_W'(ALU_NOP);
      src1_pc_q   <= 1'b0;
      src2_imm_q  <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      aluop_q     <= aluop_d;
      src1_pc_q   <= src1_pc_d;
      src2_imm_q  <= src2_imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // ------------------------------------------------------------------
  // Forwarding (evaluated every cycle, including while held)
  // ------------------------------------------------------------------
  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .reg_addr_i     (rs1_addr_q),
    .reg_data_i     (rs1_data_q),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_we),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_we),
    .memwb_result_i (memwb_result),
    .fwd_data_o     (fwd_rs1)
  );

  operand_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .reg_addr_i     (rs2_addr_q),
    .reg_data_i     (rs2_data_q),
    .exmem_rd_i     (exmem_rd),
    .exmem_we_i     (exmem_we),
    .exmem_result_i (exmem_result),
    .memwb_rd_i     (memwb_rd),
    .memwb_we_i     (memwb_we),
    .memwb_result_i (memwb_result),
    .fwd_data_o     (fwd_rs2)
  );

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign alusrc1       = src1_pc_q  ? pc_q  : fwd_rs1;
  assign alusrc2       = src2_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign aluop         = aluop_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd_addr    = rd_q;
  assign ex_reg_write  = reg_write_q && valid_q;
  assign ex_mem_read   = mem_read_q  && valid_q;
  assign ex_mem_write  = mem_write_q && valid_q;

endmodule : id_ex_operand_stage
